bpd2: RTL and testbench

BPD2 -- requirements
Module: bpd2

---
 rtl/bpd2_pkg.sv | 34 +++
 rtl/bpd2_if.sv | 53 +++++
 rtl/bpd2_sat_ctr_table.sv | 35 +++
 rtl/bpd2.sv | 198 +++++++++++++++++++
 tb/tb_bpd2.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bpd2_pkg.sv
// Shared definitions for the tournament branch predictor: counter init values,
// FSM state encoding and the saturating counter step.
// Pure declarations, no timing; no flow control.
package bpd2_pkg;

  // Widest counter the shared step function handles.
  localparam int CTR_MAX_W = 8;

  // Weakly-not-taken starting points for the global, local and chooser
  // counters. The chooser starts leaning to the local predictor.
  localparam logic [CTR_MAX_W-1:0] GCTR_INIT = 8'h01;
  localparam logic [CTR_MAX_W-1:0] LCTR_INIT = 8'h03;
  localparam logic [CTR_MAX_W-1:0] CCTR_INIT = 8'h01;

  // Two-state controller: table sweep after reset, then normal operation.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One saturating step of a width-bit counter held in the low bits of val.
  function automatic logic [CTR_MAX_W-1:0] sat_step(
    input logic [CTR_MAX_W-1:0] val,
    input logic                 up,
    input int                   width
  );
    logic [CTR_MAX_W-1:0] top;
    top = (CTR_MAX_W'(1) << width) - CTR_MAX_W'(1);
    if (up) begin
      sat_step = (val >= top) ? top : val + CTR_MAX_W'(1);
    end else begin
      sat_step = (val == '0) ? val : val - CTR_MAX_W'(1);
    end
  endfunction

endpackage

// File: rtl/bpd2_if.sv
// Bundle between the fetch/retire pipeline (master) and the predictor (slave).
// Wires only, no latency of its own.
// Backpressure is pred_rdy_o from the predictor; retire and flush are never stalled.
interface bpd2_if #(
  parameter int GHR_W   = 12,
  parameter int LHIST_W = 10,
  parameter int NCKPT   = 8
);
  localparam int TAG_W = $clog2(NCKPT);

  logic               pred_req_i;
  logic [63:0]        pred_pc_i;
  logic               pred_rdy_o;
  logic               pred_vld_o;
  logic               pred_taken_o;
  logic [TAG_W-1:0]   pred_tag_o;
  logic [GHR_W-1:0]   pred_ghr_o;
  logic [LHIST_W-1:0] pred_lhist_o;
  logic               pred_gpred_o;
  logic               pred_lpred_o;

  logic               flush_i;
  logic [TAG_W-1:0]   flush_tag_i;
  logic               flush_cond_i;
  logic               flush_dir_i;

  logic               rt_vld_i;
  logic [63:0]        rt_pc_i;
  logic [GHR_W-1:0]   rt_ghr_i;
  logic [LHIST_W-1:0] rt_lhist_i;
  logic               rt_dir_i;
  logic               rt_gpred_i;
  logic               rt_lpred_i;

  logic               init_busy_o;
  logic               ckpt_full_o;

  modport master (
    output pred_req_i, pred_pc_i,
    output flush_i, flush_tag_i, flush_cond_i, flush_dir_i,
    output rt_vld_i, rt_pc_i, rt_ghr_i, rt_lhist_i, rt_dir_i, rt_gpred_i, rt_lpred_i,
    input  pred_rdy_o, pred_vld_o, pred_taken_o, pred_tag_o, pred_ghr_o,
    input  pred_lhist_o, pred_gpred_o, pred_lpred_o, init_busy_o, ckpt_full_o
  );

  modport slave (
    input  pred_req_i, pred_pc_i,
    input  flush_i, flush_tag_i, flush_cond_i, flush_dir_i,
    input  rt_vld_i, rt_pc_i, rt_ghr_i, rt_lhist_i, rt_dir_i, rt_gpred_i, rt_lpred_i,
    output pred_rdy_o, pred_vld_o, pred_taken_o, pred_tag_o, pred_ghr_o,
    output pred_lhist_o, pred_gpred_o, pred_lpred_o, init_busy_o, ckpt_full_o
  );
endinterface

// File: rtl/bpd2_sat_ctr_table.sv
// Table of saturating counters: async read, one write port shared by init and update.
// Read is combinational; a write lands at the clock edge, so a same-cycle read sees old data.
// No flow control; init writes take priority over counter updates.
module sat_ctr_table
  import bpd2_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             init_en,
  input  logic [AW-1:0]    init_addr,
  input  logic [WIDTH-1:0] init_val,
  input  logic             upd_en,
  input  logic [AW-1:0]    upd_addr,
  input  logic             upd_up,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[rd_addr];

  // Sweep writes the init value; otherwise step the addressed counter.
  always_ff @(posedge clock) begin
    if (init_en) begin
      mem[init_addr] <= init_val;
    end else if (upd_en) begin
      mem[upd_addr] <= WIDTH'(sat_step(CTR_MAX_W'(mem[upd_addr]), upd_up, WIDTH));
    end
  end

endmodule

// File: rtl/bpd2.sv
// Tournament (global/local/chooser) conditional branch predictor with GHR checkpoints.
// Prediction is registered: pred_vld_o follows an accepted request by one cycle.
// pred_rdy_o drops during the table sweep and while all checkpoints are in use.
module bpd2
  import bpd2_pkg::*;
#(
  parameter int GHR_W     = 12,
  parameter int LHT_IDX_W = 10,
  parameter int LHIST_W   = 10,
  parameter int GCTR_W    = 2,
  parameter int LCTR_W    = 3,
  parameter int CCTR_W    = 2,
  parameter int NCKPT     = 8
) (
  input logic   clock,
  input logic   reset_n,
  bpd2_if.slave bus
);

  localparam int TAG_W = $clog2(NCKPT);
  localparam int SW_GL = (GHR_W > LHT_IDX_W) ? GHR_W : LHT_IDX_W;
  localparam int SW    = (SW_GL > LHIST_W) ? SW_GL : LHIST_W;

  logic [0:0]         state;
  logic [SW-1:0]      sweep;
  logic [GHR_W-1:0]   ghr, ghr_n;
  logic [TAG_W-1:0]   head, head_n, tail, tail_n;
  logic [TAG_W:0]     occ, occ_n;
  logic [GHR_W-1:0]   ckpt [NCKPT];
  logic [LHIST_W-1:0] lht [2**LHT_IDX_W];

  logic run, init_en, full, rdy, accept, flush_v, rt_v;

  assign run     = (state == ST_RUN);
  assign init_en = (state == ST_INIT);
  assign full    = (occ == (TAG_W+1)'(NCKPT));
  assign rdy     = run & ~full;
  assign accept  = bus.pred_req_i & rdy & ~bus.flush_i;
  // Retire and flush mean nothing while the tables are being rewritten.
  assign flush_v = bus.flush_i & run;
  assign rt_v    = bus.rt_vld_i & run;

  // Prediction-side lookup.
  logic [GHR_W-1:0]     p_gidx, r_gidx;
  logic [LHT_IDX_W-1:0] p_lidx, r_lidx;
  logic [LHIST_W-1:0]   p_lhist;
  logic [GCTR_W-1:0]    gpht_rd;
  logic [LCTR_W-1:0]    lpht_rd;
  logic [CCTR_W-1:0]    chsr_rd;
  logic                 p_gpred, p_lpred, p_taken;

  assign p_gidx  = bus.pred_pc_i[GHR_W+1:2];
  assign p_lidx  = bus.pred_pc_i[LHT_IDX_W+1:2];
  assign r_gidx  = bus.rt_pc_i[GHR_W+1:2];
  assign r_lidx  = bus.rt_pc_i[LHT_IDX_W+1:2];
  assign p_lhist = lht[p_lidx];
  assign p_gpred = gpht_rd[GCTR_W-1];
  assign p_lpred = lpht_rd[LCTR_W-1];
  assign p_taken = chsr_rd[CCTR_W-1] ? p_gpred : p_lpred;

  sat_ctr_table #(.DEPTH(2**GHR_W), .WIDTH(GCTR_W)) u_gpht (
    .clock     (clock),
    .init_en   (init_en),
    .init_addr (sweep[GHR_W-1:0]),
    .init_val  (GCTR_W'(GCTR_INIT)),
    .upd_en    (rt_v),
    .upd_addr  (r_gidx ^ bus.rt_ghr_i),
    .upd_up    (bus.rt_dir_i),
    .rd_addr   (p_gidx ^ ghr),
    .rd_data   (gpht_rd)
  );

  sat_ctr_table #(.DEPTH(2**LHIST_W), .WIDTH(LCTR_W)) u_lpht (
    .clock     (clock),
    .init_en   (init_en),
    .init_addr (sweep[LHIST_W-1:0]),
    .init_val  (LCTR_W'(LCTR_INIT)),
    .upd_en    (rt_v),
    .upd_addr  (bus.rt_lhist_i),
    .upd_up    (bus.rt_dir_i),
    .rd_addr   (p_lhist),
    .rd_data   (lpht_rd)
  );

  // The chooser only learns when the two predictors disagreed.
  sat_ctr_table #(.DEPTH(2**GHR_W), .WIDTH(CCTR_W)) u_chsr (
    .clock     (clock),
    .init_en   (init_en),
    .init_addr (sweep[GHR_W-1:0]),
    .init_val  (CCTR_W'(CCTR_INIT)),
    .upd_en    (rt_v & (bus.rt_gpred_i != bus.rt_lpred_i)),
    .upd_addr  (r_gidx),
    .upd_up    (bus.rt_gpred_i == bus.rt_dir_i),
    .rd_addr   (p_gidx),
    .rd_data   (chsr_rd)
  );

  // Local history table: cleared by the sweep, shifted by each retire.
  always_ff @(posedge clock) begin
    if (init_en) begin
      lht[sweep[LHT_IDX_W-1:0]] <= '0;
    end else if (rt_v) begin
      lht[r_lidx] <= {bus.rt_lhist_i[LHIST_W-2:0], bus.rt_dir_i};
    end
  end

  // Each accepted prediction saves the GHR it was made with.
  always_ff @(posedge clock) begin
    if (accept) begin
      ckpt[tail] <= ghr;
    end
  end

  // Next GHR / pointer state; the retire is folded in before any flush.
  always_comb begin
    head_n = head + TAG_W'(rt_v);
    tail_n = tail;
    ghr_n  = ghr;
    occ_n  = occ;
    if (flush_v) begin
      tail_n = bus.flush_tag_i + TAG_W'(1);
      occ_n  = {1'b0, TAG_W'(tail_n - head_n)};
      ghr_n  = bus.flush_cond_i ? {ckpt[bus.flush_tag_i][GHR_W-2:0], bus.flush_dir_i}
                                : ckpt[bus.flush_tag_i];
    end else begin
      if (accept) begin
        tail_n = tail + TAG_W'(1);
        ghr_n  = {ghr[GHR_W-2:0], p_taken};
      end
      occ_n = occ + (TAG_W+1)'(accept) - (TAG_W+1)'(rt_v);
    end
  end

  // Controller: sweep every table entry once, then run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      sweep <= '0;
      ghr   <= '0;
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
    end else begin
      if (state == ST_INIT) begin
        sweep <= sweep + SW'(1);
        if (&sweep) state <= ST_RUN;
      end
      ghr  <= ghr_n;
      head <= head_n;
      tail <= tail_n;
      occ  <= occ_n;
    end
  end

  logic               pred_vld, pred_taken, pred_gpred, pred_lpred;
  logic [TAG_W-1:0]   pred_tag;
  logic [GHR_W-1:0]   pred_ghr;
  logic [LHIST_W-1:0] pred_lhist;

  // Register the prediction and its metadata for the cycle after accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      pred_tag   <= '0;
      pred_ghr   <= '0;
      pred_lhist <= '0;
      pred_gpred <= 1'b0;
      pred_lpred <= 1'b0;
    end else begin
      pred_vld <= accept;
      if (accept) begin
        pred_taken <= p_taken;
        pred_tag   <= tail;
        pred_ghr   <= ghr;
        pred_lhist <= p_lhist;
        pred_gpred <= p_gpred;
        pred_lpred <= p_lpred;
      end
    end
  end

  assign bus.pred_rdy_o   = rdy;
  assign bus.pred_vld_o   = pred_vld;
  assign bus.pred_taken_o = pred_taken;
  assign bus.pred_tag_o   = pred_tag;
  assign bus.pred_ghr_o   = pred_ghr;
  assign bus.pred_lhist_o = pred_lhist;
  assign bus.pred_gpred_o = pred_gpred;
  assign bus.pred_lpred_o = pred_lpred;
  assign bus.init_busy_o  = init_en;
  assign bus.ckpt_full_o  = full;

  // PC bits outside the index fields and the top history bit are not needed.
  logic unused;
  assign unused = ^{bus.pred_pc_i, bus.rt_pc_i, bus.rt_lhist_i, sweep};

endmodule

// File: tb/tb_bpd2.sv
// Directed bench for bpd2 with hand-computed expectations.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
// Checks reset, init sweep, prediction, training, checkpoint full, flush and mid-run reset.
module tb_bpd2;

  logic clock;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  bpd2_if #(.GHR_W(12), .LHIST_W(10), .NCKPT(8)) bus ();

  bpd2 u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [63:0] PC_A = 64'h4;
  localparam logic [63:0] PC_B = 64'h8;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_vld"},   64'(bus.pred_vld_o),   64'd0);
    chk({tag, "_taken"}, 64'(bus.pred_taken_o), 64'd0);
    chk({tag, "_tag"},   64'(bus.pred_tag_o),   64'd0);
    chk({tag, "_ghr"},   64'(bus.pred_ghr_o),   64'd0);
    chk({tag, "_lhist"}, 64'(bus.pred_lhist_o), 64'd0);
    chk({tag, "_gl"},    64'({bus.pred_gpred_o, bus.pred_lpred_o}), 64'd0);
    chk({tag, "_rdy"},   64'(bus.pred_rdy_o),   64'd0);
    chk({tag, "_full"},  64'(bus.ckpt_full_o),  64'd0);
    chk({tag, "_busy"},  64'(bus.init_busy_o),  64'd1);
  endtask

  // Count INIT cycles; optionally pulse flush/retire early in INIT.
  task automatic wait_init(input bit poke);
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (bus.init_busy_o && n < 10000) begin
      if (bus.pred_rdy_o) rdy_seen = 1'b1;
      if (poke && n < 3) begin
        bus.flush_i = 1'b1; bus.flush_tag_i = 3'd5; bus.rt_vld_i = 1'b1;
      end else begin
        bus.flush_i = 1'b0; bus.rt_vld_i = 1'b0;
      end
      n++;
      step();
    end
    bus.flush_i = 1'b0; bus.rt_vld_i = 1'b0; bus.flush_tag_i = '0;
    chk("init_len", 64'(n), 64'd4096);
    chk("rdy_in_init", 64'(rdy_seen), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    wait_init(1'b0);
  endtask

  // One accepted request; checks the registered answer a cycle later.
  task automatic pred1(input logic [63:0] pc, input logic exp_taken, input int exp_tag,
                       input int exp_ghr);
    bus.pred_req_i = 1'b1;
    bus.pred_pc_i  = pc;
    chk("pred_rdy", 64'(bus.pred_rdy_o), 64'd1);
    step();
    bus.pred_req_i = 1'b0;
    chk("pred_vld",   64'(bus.pred_vld_o),   64'd1);
    chk("pred_taken", 64'(bus.pred_taken_o), 64'(exp_taken));
    chk("pred_tag",   64'(bus.pred_tag_o),   64'(exp_tag));
    chk("pred_ghr",   64'(bus.pred_ghr_o),   64'(exp_ghr));
  endtask

  task automatic retire1(input logic [63:0] pc, input logic [11:0] ghr, input logic [9:0] lhist,
                         input logic dir, input logic gp, input logic lp);
    bus.rt_vld_i = 1'b1; bus.rt_pc_i = pc; bus.rt_ghr_i = ghr; bus.rt_lhist_i = lhist;
    bus.rt_dir_i = dir; bus.rt_gpred_i = gp; bus.rt_lpred_i = lp;
    step();
    bus.rt_vld_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.pred_req_i = 1'b0; bus.pred_pc_i = '0;
    bus.flush_i = 1'b0; bus.flush_tag_i = '0; bus.flush_cond_i = 1'b0; bus.flush_dir_i = 1'b0;
    bus.rt_vld_i = 1'b0; bus.rt_pc_i = '0; bus.rt_ghr_i = '0; bus.rt_lhist_i = '0;
    bus.rt_dir_i = 1'b0; bus.rt_gpred_i = 1'b0; bus.rt_lpred_i = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 reset_chk("rst0");
    step();
    step();
    reset_n = 1'b1;
    wait_init(1'b0);

    // First prediction from freshly initialised tables.
    pred1(64'h1000, 1'b0, 0, 0);
    chk("first_lhist", 64'(bus.pred_lhist_o), 64'd0);
    chk("first_gl", 64'({bus.pred_gpred_o, bus.pred_lpred_o}), 64'd0);
    retire1(64'h1000, 12'd0, 10'd0, 1'b0, 1'b0, 1'b0);

    // Train GPHT entry for PC 0x40 to strongly taken.
    for (int i = 0; i < 4; i++) pred1(64'h40, 1'b0, 1 + i, 0);
    for (int i = 0; i < 4; i++) retire1(64'h40, 12'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    pred1(64'h40, 1'b0, 5, 0);
    chk("trained_gpred", 64'(bus.pred_gpred_o), 64'd1);
    chk("trained_lhist", 64'(bus.pred_lhist_o), 64'd1);
    chk("trained_lpred", 64'(bus.pred_lpred_o), 64'd0);
    // LPHT[0] was pushed to 110 by those retires; chooser selects local.
    pred1(64'h1000, 1'b1, 6, 0);
    chk("lpht0_lpred", 64'(bus.pred_lpred_o), 64'd1);
    chk("lpht0_gpred", 64'(bus.pred_gpred_o), 64'd0);
    pred1(64'h40, 1'b0, 7, 1);

    // Checkpoint full after eight accepts.
    do_reset();
    for (int i = 0; i < 8; i++) pred1(64'h1000, 1'b0, i, 0);
    chk("full_after8", 64'(bus.ckpt_full_o), 64'd1);
    chk("rdy_when_full", 64'(bus.pred_rdy_o), 64'd0);
    bus.pred_req_i = 1'b1; bus.pred_pc_i = 64'h1000;
    step();
    bus.pred_req_i = 1'b0;
    chk("ninth_not_answered", 64'(bus.pred_vld_o), 64'd0);
    retire1(64'h1000, 12'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    chk("rdy_after_retire", 64'(bus.pred_rdy_o), 64'd1);
    chk("full_after_retire", 64'(bus.ckpt_full_o), 64'd0);

    // Make PC_A taken via LHT[1]=0x3FF and LPHT[0x3FF]; wrap tail back to 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pred1(PC_B, 1'b0, i, 0);
      retire1(PC_A, 12'd0, 10'h3FF, 1'b1, 1'b0, 1'b0);
    end
    pred1(PC_A, 1'b1, 0, 0);
    chk("a_lhist", 64'(bus.pred_lhist_o), 64'h3FF);
    pred1(PC_A, 1'b1, 1, 1);
    pred1(PC_B, 1'b0, 2, 3);
    pred1(PC_A, 1'b1, 3, 6);
    // Flush tag 1 as a not-taken conditional, with a request held high.
    bus.flush_i = 1'b1; bus.flush_tag_i = 3'd1; bus.flush_cond_i = 1'b1; bus.flush_dir_i = 1'b0;
    bus.pred_req_i = 1'b1; bus.pred_pc_i = PC_B;
    step();
    bus.flush_i = 1'b0; bus.flush_cond_i = 1'b0;
    chk("no_vld_after_flush", 64'(bus.pred_vld_o), 64'd0);
    step();
    bus.pred_req_i = 1'b0;
    chk("post_flush_vld", 64'(bus.pred_vld_o), 64'd1);
    chk("post_flush_tag", 64'(bus.pred_tag_o), 64'd2);
    chk("post_flush_ghr", 64'(bus.pred_ghr_o), 64'd2);

    // Retire tag 0 and flush tag 0 together: ring empties, next tag is 1.
    bus.flush_i = 1'b1; bus.flush_tag_i = 3'd0; bus.flush_cond_i = 1'b0;
    retire1(PC_B, 12'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    bus.flush_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pred1(PC_B, 1'b0, (1 + i) % 8, 0);
      chk("refill_full", 64'(bus.ckpt_full_o), 64'(i == 7));
    end

    // Reset in the middle of traffic with five checkpoints live.
    for (int i = 0; i < 4; i++) retire1(PC_B, 12'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    pred1(PC_B, 1'b0, 1, 0);
    #2 reset_n = 1'b0;
    #1 reset_chk("rst_mid");
    step();
    reset_n = 1'b1;
    wait_init(1'b1);
    pred1(PC_B, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
